// File: rtl/mem_ctrl.sv
// mem_ctrl: single-access memory controller with four-phase handshake; optional timeout via MEM_CTRL_TIMEOUT_EN
module mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MC,
  input  logic [15:0] addr,
  input  logic [15:0] WRdata,
  output logic [15:0] Mdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  state_t state, next;
  logic accept, tmo;
  assign accept = (state == IDLE) && (MC != 2'b00);
`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = (state == ACCESS) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
  // cycles spent in ACCESS without an acknowledge
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (accept) cnt <= '0;
    else if (state == ACCESS && !mem_ack) cnt <= cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next state: ack beats timeout; release waits for ack to drop
  always_comb begin
    next = state;
    if (state == IDLE) next = accept ? ACCESS : IDLE;
    else if (state == ACCESS) next = (mem_ack || tmo) ? RELEASE : ACCESS;
    else next = mem_ack ? RELEASE : IDLE;
  end
  // registered outputs and request latch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Mdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      busy    <= next != IDLE;
      mem_req <= next == ACCESS;
      done    <= (state == ACCESS) && (next == RELEASE);
      if (accept) begin
        mem_we    <= MC[0];
        mem_addr  <= addr;
        mem_wdata <= WRdata;
        err       <= 1'b0;
      end
      if (state == ACCESS && mem_ack && !mem_we) Mdata <= mem_rdata;
      if (tmo) err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl with a transaction-level model
module tb_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] MC = 2'b00;
  logic [15:0] addr = '0, WRdata = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic [15:0] Mdata, mem_addr, mem_wdata;
  logic busy, done, err, mem_req, mem_we;
  int errors = 0, checks = 0;
  logic [15:0] exp_mdata = '0;

  mem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .MC(MC), .addr(addr), .WRdata(WRdata), .Mdata(Mdata),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic do_access(input logic [1:0] mc, input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, input logic [1:0] mc_during, input int delay, input int hold);
    logic we;
    we = mc[0];
    MC = mc; addr = a; WRdata = wd; mem_rdata = rd; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_req, mem_we, done, err} !== {2'b11, we, 2'b00} || mem_addr !== a || mem_wdata !== wd) begin
      errors++;
      $display("FAIL accept: busy/req/we/done/err=%b%b%b%b%b addr=%h wdata=%h, expected 11%b00 addr=%h wdata=%h",
               busy, mem_req, mem_we, done, err, mem_addr, mem_wdata, we, a, wd);
    end
    MC = mc_during; addr = 16'($urandom); WRdata = 16'($urandom);
    repeat (delay) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_req, mem_we, done, err} !== {2'b11, we, 2'b00} || mem_addr !== a || mem_wdata !== wd) begin
        errors++;
        $display("FAIL hold: busy/req/we/done/err=%b%b%b%b%b addr=%h wdata=%h, expected 11%b00 addr=%h wdata=%h",
                 busy, mem_req, mem_we, done, err, mem_addr, mem_wdata, we, a, wd);
      end
    end
    mem_ack = 1'b1;
    @(negedge clk);
    if (!we) exp_mdata = rd;
    checks++;
    if ({busy, mem_req, done, err} !== 4'b1010 || Mdata !== exp_mdata) begin
      errors++;
      $display("FAIL complete: busy/req/done/err=%b%b%b%b Mdata=%h, expected 1010 Mdata=%h",
               busy, mem_req, done, err, Mdata, exp_mdata);
    end
    mem_rdata = 16'($urandom);
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_req, done} !== 3'b100 || Mdata !== exp_mdata) begin
        errors++;
        $display("FAIL release: busy/req/done=%b%b%b Mdata=%h, expected 100 Mdata=%h",
                 busy, mem_req, done, Mdata, exp_mdata);
      end
    end
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_req, done, err} !== 4'b0000 || Mdata !== exp_mdata) begin
      errors++;
      $display("FAIL idle: busy/req/done/err=%b%b%b%b Mdata=%h, expected 0000 Mdata=%h",
               busy, mem_req, done, err, Mdata, exp_mdata);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; MC = 2'b10; addr = 16'hFFFF; WRdata = 16'hFFFF;
    #2;
    checks++;
    if ({busy, done, err, mem_req, mem_we} !== 5'b0 || Mdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset: busy/done/err/req/we=%b%b%b%b%b Mdata=%h addr=%h wdata=%h, expected all zero",
               busy, done, err, mem_req, mem_we, Mdata, mem_addr, mem_wdata);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({busy, done, mem_req} !== 3'b000 || mem_addr !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold: busy/done/req=%b%b%b addr=%h, expected 000 addr=0000", busy, done, mem_req, mem_addr);
      end
    end
  endtask

  task automatic test_read;
    rst = 1'b0;
    do_access(2'b10, 16'h0040, 16'h0000, 16'hBEEF, 2'b00, 3, 0);
  endtask

  task automatic test_write;
    do_access(2'b01, 16'h0100, 16'h1234, 16'h5555, 2'b00, 2, 1);
  endtask

  task automatic test_priority;
    do_access(2'b11, 16'h0200, 16'hA5A5, 16'h7777, 2'b10, 2, 0);
    do_access(2'b10, 16'h0300, 16'h0000, 16'hCAFE, 2'b00, 1, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_req, done} !== 3'b000 || Mdata !== 16'hCAFE) begin
        errors++;
        $display("FAIL no_extra: busy/req/done=%b%b%b Mdata=%h, expected 000 Mdata=cafe", busy, mem_req, done, Mdata);
      end
    end
  endtask

  task automatic test_ack_held;
    do_access(2'b10, 16'h0044, 16'h0000, 16'h0F0F, 2'b00, 0, 5);
  endtask

`ifdef MEM_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    n = 0;
    MC = 2'b10; addr = 16'h0500; mem_rdata = 16'h9999; mem_ack = 1'b0;
    @(negedge clk);
    MC = 2'b00;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16 || {busy, done, err} !== 3'b111 || Mdata !== exp_mdata) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d busy/done/err=%b%b%b Mdata=%h, expected 16 111 Mdata=%h",
               n, busy, done, err, Mdata, exp_mdata);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, done, err} !== 3'b001) begin
        errors++;
        $display("FAIL err_sticky: busy/done/err=%b%b%b, expected 001", busy, done, err);
      end
    end
    do_access(2'b10, 16'h0600, 16'h0000, 16'h1111, 2'b00, 1, 0);
    do_access(2'b10, 16'h0700, 16'h0000, 16'h2222, 2'b00, 15, 0);
  endtask
`else
  task automatic test_no_timeout;
    do_access(2'b10, 16'h0800, 16'h0000, 16'h3333, 2'b00, 40, 0);
  endtask
`endif

  task automatic test_reset_mid;
    MC = 2'b10; addr = 16'h0900; mem_rdata = 16'h4444; mem_ack = 1'b0;
    @(negedge clk);
    MC = 2'b00;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_mdata = 16'h0000;
    checks++;
    if ({busy, mem_req, done} !== 3'b000 || Mdata !== 16'h0 || mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: busy/req/done=%b%b%b Mdata=%h addr=%h, expected 000 0000 0000",
               busy, mem_req, done, Mdata, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_req, done} !== 3'b000 || Mdata !== 16'h0) begin
        errors++;
        $display("FAIL after_reset: busy/req/done=%b%b%b Mdata=%h, expected 000 0000", busy, mem_req, done, Mdata);
      end
    end
  endtask

  task automatic test_random;
    int idle;
    for (int i = 0; i < 25; i++) begin
      idle = int'($urandom_range(0, 2));
      MC = 2'b00;
      repeat (idle) begin
        @(negedge clk);
        checks++;
        if ({busy, mem_req, done} !== 3'b000 || Mdata !== exp_mdata) begin
          errors++;
          $display("FAIL rand_idle: busy/req/done=%b%b%b Mdata=%h, expected 000 Mdata=%h",
                   busy, mem_req, done, Mdata, exp_mdata);
        end
      end
      do_access(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 16'($urandom), 2'b00,
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_priority;
    test_ack_held;
`ifdef MEM_CTRL_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
